// File: rtl/belt_exec_if.sv
// Operation issue, belt read-port and drop signals between the execute stage and its neighbours.
// The execute stage uses the slave modport; the issuing side and the belt use the master modport.
interface belt_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [31:0] in_imm;
  logic [3:0]  belt_r1;
  logic [3:0]  belt_r2;
  logic [31:0] belt_rdata1;
  logic [31:0] belt_rdata2;
  logic        drop;
  logic [31:0] wdata;
  logic        err;
  logic        busy;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_imm, belt_rdata1, belt_rdata2,
    output in_ready, belt_r1, belt_r2, drop, wdata, err, busy
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_imm, belt_rdata1, belt_rdata2,
    input  in_ready, belt_r1, belt_r2, drop, wdata, err, busy
  );
endinterface

// File: rtl/belt_exec.sv
// Single-issue execute stage for a 16-entry belt: fetch operands by belt position,
// compute (iterative shift-add for MUL) and drop one result per operation.
module belt_exec (
  input  logic         clk,
  input  logic         rst,
  belt_exec_if.slave   bus
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_CONST = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_PICK  = 4'd12;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MUL, DROP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op;
  logic [31:0] imm;
  logic [31:0] result;
  logic [31:0] mcand, mplier, acc, acc_step;
  logic [4:0]  cnt;
  logic        err_q;
  logic [3:0]  r1, r2;
  logic        accept, illegal, alu_done, mul_done;

  function automatic logic is_illegal(input logic [3:0] f);
    return (f > OP_PICK);
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] k);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      OP_ADD:   alu = a + b;
      OP_SUB:   alu = a - b;
      OP_AND:   alu = a & b;
      OP_OR:    alu = a | b;
      OP_XOR:   alu = a ^ b;
      OP_SHL:   alu = a << b[4:0];
      OP_SHR:   alu = a >> b[4:0];
      OP_SRA:   alu = sa >>> b[4:0];
      OP_SLT:   alu = {31'd0, sa < sb};
      OP_SLTU:  alu = {31'd0, a < b};
      OP_CONST: alu = k;
      OP_PICK:  alu = a;
      default:  alu = 32'd0;
    endcase
  endfunction

  assign accept   = (state == IDLE) && bus.in_valid;
  assign illegal  = is_illegal(op);
  assign alu_done = (state == EXEC) && !illegal && (op != OP_MUL);
  assign mul_done = (state == MUL) && (cnt == 5'd31);
  assign acc_step = acc + (mplier[0] ? mcand : 32'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if (illegal)             state_nxt = IDLE;
        else if (op == OP_MUL)   state_nxt = MUL;
        else                     state_nxt = DROP;
      end
      MUL:   if (cnt == 5'd31) state_nxt = DROP;
      DROP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architecturally visible state: reset clears these.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      err_q  <= 1'b0;
      r1     <= 4'd0;
      r2     <= 4'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
    end else begin
      state <= state_nxt;
      err_q <= (state == EXEC) && illegal;
      if (accept) begin
        r1 <= bus.in_a;
        r2 <= bus.in_b;
      end
      if (state == EXEC)     cnt <= 5'd0;
      else if (state == MUL) cnt <= cnt + 5'd1;
      if (alu_done)
        result <= alu(op, bus.belt_rdata1, bus.belt_rdata2, imm);
      else if (mul_done)
        result <= acc_step;
    end
  end

  // Operation capture and shift-add multiplier datapath; always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op  <= bus.in_op;
      imm <= bus.in_imm;
    end
    if (state == EXEC) begin
      mcand  <= bus.belt_rdata1;
      mplier <= bus.belt_rdata2;
      acc    <= 32'd0;
    end else if (state == MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.drop     = (state == DROP);
  assign bus.wdata    = result;
  assign bus.err      = err_q;
  assign bus.belt_r1  = r1;
  assign bus.belt_r2  = r2;

endmodule

// File: tb/tb_belt_exec.sv
// Bench for belt_exec: a behavioural 16-entry belt, directed operations with
// hand-computed results, and a scoreboard monitor that checks every drop/err pulse.
module tb_belt_exec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  belt_exec_if bus();
  belt_exec dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
    int          at;
  } exp_t;
  exp_t q[$];

  // Belt: position 0 is the most recent drop; read data registered one cycle after the position.
  logic [31:0] belt [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) belt[i] <= 32'd0;
      bus.belt_rdata1 <= 32'd0;
      bus.belt_rdata2 <= 32'd0;
    end else begin
      if (bus.drop) begin
        for (int i = 15; i > 0; i--) belt[i] <= belt[i-1];
        belt[0] <= bus.wdata;
      end
      bus.belt_rdata1 <= belt[bus.belt_r1];
      bus.belt_rdata2 <= belt[bus.belt_r2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.drop === 1'b1 || bus.err === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: drop=%b err=%b wdata=%h cyc=%0d", bus.drop, bus.err, bus.wdata, cyc);
      end else begin
        e = q.pop_front();
        chk("out_drop", {31'd0, bus.drop}, {31'd0, !e.is_err});
        chk("out_err", {31'd0, bus.err}, {31'd0, e.is_err});
        chk("out_cycle", 32'(cyc), 32'(e.at));
        if (!e.is_err) chk("wdata", bus.wdata, e.val);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [31:0] imm, output int e);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready=%b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_imm   = imm;
    @(posedge clk);
    #1;
    e = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [31:0] imm, input logic [31:0] val);
    int e;
    exp_t x;
    issue(op, a, b, imm, e);
    x.is_err = 1'b0;
    x.val    = val;
    x.at     = (op == 4'd11) ? e + 34 : e + 2;
    q.push_back(x);
  endtask

  initial begin
    int e, c, n;
    exp_t x;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = 4'd0;
    bus.in_a     = 4'd0;
    bus.in_b     = 4'd0;
    bus.in_imm   = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_drop", {31'd0, bus.drop}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_r1", {28'd0, bus.belt_r1}, 32'd0);
    chk("rst_r2", {28'd0, bus.belt_r2}, 32'd0);

    run(4'd10, 4'd0, 4'd0, 32'd5, 32'd5);
    run(4'd10, 4'd0, 4'd0, 32'd7, 32'd7);
    issue(4'd0, 4'd0, 4'd1, 32'd0, e);
    x.is_err = 1'b0; x.val = 32'd12; x.at = e + 2;
    q.push_back(x);
    chk("add_ready_c1", {31'd0, bus.in_ready}, 32'd0);
    chk("add_r1_hold", {28'd0, bus.belt_r1}, 32'd0);
    chk("add_r2_hold", {28'd0, bus.belt_r2}, 32'd1);
    @(negedge clk);
    chk("add_ready_c2", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("add_ready_c3", {31'd0, bus.in_ready}, 32'd0);
    chk("add_busy_c3", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("add_wdata_hold", bus.wdata, 32'd12);

    run(4'd10, 4'd0, 4'd0, 32'hDEADBEEF, 32'hDEADBEEF);
    run(4'd1, 4'd0, 4'd0, 32'd0, 32'd0);

    run(4'd10, 4'd0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(4'd10, 4'd0, 4'd0, 32'd2, 32'd2);
    run(4'd11, 4'd0, 4'd1, 32'd0, 32'hFFFFFFFE);
    run(4'd10, 4'd0, 4'd0, 32'h80000000, 32'h80000000);
    run(4'd10, 4'd0, 4'd0, 32'd4, 32'd4);
    run(4'd7, 4'd1, 4'd0, 32'd0, 32'hF8000000);
    run(4'd10, 4'd0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(4'd10, 4'd0, 4'd0, 32'd1, 32'd1);
    run(4'd8, 4'd1, 4'd0, 32'd0, 32'd1);
    run(4'd9, 4'd2, 4'd1, 32'd0, 32'd0);
    run(4'd12, 4'd3, 4'd0, 32'd0, 32'hFFFFFFFF);
    run(4'd4, 4'd0, 4'd2, 32'd0, 32'hFFFFFFFE);
    run(4'd5, 4'd3, 4'd4, 32'd0, 32'd2);

    issue(4'd14, 4'd0, 4'd0, 32'd0, e);
    x.is_err = 1'b1; x.val = 32'd0; x.at = e + 2;
    q.push_back(x);
    repeat (2) @(negedge clk);
    chk("illegal_ready_c3", {31'd0, bus.in_ready}, 32'd1);
    chk("illegal_busy_c3", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: valid held high; odd slots offer an illegal op that must never be taken.
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    c = cyc;
    for (int j = 0; j < 3; j++) begin
      x.is_err = 1'b0; x.val = 32'd100 + 32'(4 * j); x.at = c + 3 + 4 * j;
      q.push_back(x);
    end
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = (k % 2 == 1) ? 4'd14 : 4'd10;
      bus.in_imm   = 32'd100 + 32'(k);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    // Reset partway through a MUL: no drop, no err, outputs back to reset values.
    issue(4'd11, 4'd0, 4'd1, 32'd0, e);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_drop", {31'd0, bus.drop}, 32'd0);
    chk("mrst_err", {31'd0, bus.err}, 32'd0);
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mrst_wdata", bus.wdata, 32'd0);
    chk("mrst_r1", {28'd0, bus.belt_r1}, 32'd0);
    repeat (40) @(negedge clk);

    run(4'd10, 4'd0, 4'd0, 32'd3, 32'd3);
    run(4'd10, 4'd0, 4'd0, 32'd4, 32'd4);
    run(4'd0, 4'd0, 4'd1, 32'd0, 32'd7);

    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
